sm_gpio_debounce: RTL and testbench
===================================

# sm_gpio_debounce

Input conditioning stage between the board's raw GPIO pins and the `GpioInput` port of `sm_top`. Each bit is synchronised into `clk`, then debounced by a per-bit counter. The block presents a glitch-free `gpio_stable` vector to the CPU, plus one-cycle rise/fall pulses, a sticky edge-status register with write-one-to-clear, and a masked interrupt request.

## Interface

Parameters:
- `GPIO_SIZE`, 16, number of GPIO bits (matches `` `GPIO_SIZE ``)
- `DEBOUNCE_CYCLES`, 4, consecutive cycles a new level must persist (legal range 1..65535)
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES+1)`, per-bit counter width (derived, not overridden)

Ports:
- `clk`  in  1  system clock, the same clock as the CPU
- `rst`  in  1  synchronous reset, active-high
- `gpio_raw`  in  GPIO_SIZE  asynchronous pin levels
- `status_clr`  in  GPIO_SIZE  write-one-to-clear strobe for `edge_status`
- `irq_mask`  in  GPIO_SIZE  1 = bit may raise `irq`
- `gpio_stable`  out  GPIO_SIZE  debounced level, drives `sm_top.GpioInput`
- `gpio_rise`  out  GPIO_SIZE  one-cycle pulse when a stable bit goes 0→1
- `gpio_fall`  out  GPIO_SIZE  one-cycle pulse when a stable bit goes 1→0
- `edge_status`  out  GPIO_SIZE  sticky per-bit "edge seen" flags
- `irq`  out  1  `|(edge_status & irq_mask)`, registered

## Operation

Per bit `i`, all state is updated on `posedge clk`:
- **Synchroniser.** Two flops: `s1 <= gpio_raw[i]`, then `s2 <= s1`. No logic is placed between the two flops.
- **Debounce counter `cnt`.**
  - If `s2 == stable`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2`, `cnt <= 0`, and assert `rise` (when `s2`=1) or `fall` (when `s2`=0) for exactly this one cycle.
  - Else: `cnt <= cnt+1`.
- **Pulses.** `gpio_rise` and `gpio_fall` are registered. They are high only in the cycle following the update edge, aligned with the new `gpio_stable` value. For any bit, rise and fall are never asserted together.
- **Edge status.** `edge_status[i] <= (edge_status[i] & ~status_clr[i]) | rise_next[i] | fall_next[i]`. When set and clear occur in the same cycle, set wins.
- **Interrupt.** `irq` is computed from the next-state `edge_status` and `irq_mask`, then registered. It is therefore valid in the same cycle as the updated `edge_status`.
- **Reset.** `rst`=1 at an edge zeroes `s1`, `s2`, `cnt`, `gpio_stable`, `gpio_rise`, `gpio_fall`, `edge_status` and `irq`. This is the reset value of every output.
  - If a pin is held high through reset, it produces a normal rise pulse `DEBOUNCE_CYCLES+2` edges after release.
  - Reset asserted mid-count discards the count.
- **Glitch rejection.** A level that reverts before being held for `DEBOUNCE_CYCLES` cycles at `s2` returns `cnt` to 0 and produces no output change.
- **Width rule.** `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so there is no wrap-around.
- **Bit independence.** Bits are fully independent, and simultaneous changes on several bits are handled in parallel.

## Timing

- **Latency.** `gpio_raw` changes before edge 0 and stays stable. Then `s1` updates after edge 0 and `s2` after edge 1, and `cnt` reaches `DEBOUNCE_CYCLES-1` after edge `DEBOUNCE_CYCLES`. `gpio_stable`, the pulse, `edge_status` and `irq` all update after edge `DEBOUNCE_CYCLES+1`, which is `DEBOUNCE_CYCLES+2` edges total.
  - With the default of 4, outputs change after edge 5.
  - With `DEBOUNCE_CYCLES`=1, outputs change after edge 2.
- **Minimum accepted pulse width** at `gpio_raw`: `DEBOUNCE_CYCLES` cycles. Anything shorter is rejected.
- **Clear latency.** A `status_clr` bit sampled at an edge clears `edge_status` and updates `irq` after that edge.
- **Output timing.** All outputs are registered, with no combinational path from any input to any output.

## Test plan

1. **Reset and default debounce.** Hold `rst`=1 for 4 edges with `gpio_raw`=16'h0000, then release and drive 16'h000a. `gpio_stable` stays 0 through edge 4 and becomes 16'h000a after edge 5. `gpio_rise`=16'h000a for exactly one cycle. `edge_status`=16'h000a. `irq`=1 if `irq_mask`=16'hffff.
2. **Glitch rejection.** With `gpio_stable`=0, drive a 3-cycle pulse 16'h0001 on `gpio_raw`, then 0. `gpio_stable`, `gpio_rise` and `edge_status` stay 0, and `cnt` returns to 0.
3. **Fall detection and clear.** From `gpio_stable`=16'h000a, drive 16'h0002. `gpio_fall`=16'h0008 for one cycle after edge 5. Then pulse `status_clr`=16'h0008 for one cycle: `edge_status` drops bit 3, and `irq` follows the masked result.
4. **Set beats clear.** Assert `status_clr` for bit 0 in the same cycle its rise is generated. `edge_status[0]`=1 afterwards.
5. **Masking.** With `irq_mask`=16'h0000, an edge on bit 5 sets `edge_status[5]` while `irq` stays 0. Setting `irq_mask[5]`=1 then raises `irq` on the next edge.
6. **Mid-count reset and parameter edge.** Assert `rst` during a pending count (`cnt`=2): all outputs are 0, and no pulse appears afterwards unless the pin is still high, in which case a full `DEBOUNCE_CYCLES+2` latency applies. Separately, rerun scenario 1 with `DEBOUNCE_CYCLES`=1: `gpio_stable` updates after edge 2.

Source files
------------

// File: rtl/sm_gpio_debounce.sv
// sm_gpio_debounce: two-flop synchronise, per-bit debounce, edge pulses, sticky W1C status and masked irq
module sm_gpio_debounce #(
  parameter int GPIO_SIZE = 16,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [GPIO_SIZE-1:0] gpio_raw,
  input  logic [GPIO_SIZE-1:0] status_clr,
  input  logic [GPIO_SIZE-1:0] irq_mask,
  output logic [GPIO_SIZE-1:0] gpio_stable,
  output logic [GPIO_SIZE-1:0] gpio_rise,
  output logic [GPIO_SIZE-1:0] gpio_fall,
  output logic [GPIO_SIZE-1:0] edge_status,
  output logic                 irq
);
  logic [GPIO_SIZE-1:0] s1_q, s2_q, hit;
  logic [GPIO_SIZE-1:0] stable_q, stable_d, rise_q, rise_d, fall_q, fall_d, status_q, status_d;
  logic [CNT_W-1:0] cnt_q [GPIO_SIZE];
  logic [CNT_W-1:0] cnt_d [GPIO_SIZE];
  logic irq_q, irq_d;
  always_comb begin
    for (int i = 0; i < GPIO_SIZE; i++) begin
      hit[i] = (s2_q[i] != stable_q[i]) && (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1));
      cnt_d[i] = (s2_q[i] == stable_q[i]) || hit[i] ? '0 : cnt_q[i] + CNT_W'(1);
    end
    stable_d = (stable_q & ~hit) | (s2_q & hit);
    rise_d = hit & s2_q;
    fall_d = hit & ~s2_q;
    status_d = (status_q & ~status_clr) | rise_d | fall_d;
    irq_d = |(status_d & irq_mask);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      cnt_q <= '{default: '0};
      stable_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      status_q <= '0;
      irq_q <= 1'b0;
    end else begin
      s1_q <= gpio_raw;
      s2_q <= s1_q;
      cnt_q <= cnt_d;
      stable_q <= stable_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      status_q <= status_d;
      irq_q <= irq_d;
    end
  end
  assign gpio_stable = stable_q;
  assign gpio_rise = rise_q;
  assign gpio_fall = fall_q;
  assign edge_status = status_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_sm_gpio_debounce.sv
// tb_sm_gpio_debounce: directed stimulus with a cycle-tagged expectation queue checked by a monitor
module tb_sm_gpio_debounce;
  typedef struct {
    int cyc;
    int u;
    string name;
    logic [15:0] st, ri, fa, es;
    logic irq;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  logic [15:0] raw, clr, mask;
  logic [15:0] st0, ri0, fa0, es0, st1, ri1, fa1, es1;
  logic irq0, irq1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  sm_gpio_debounce #(.GPIO_SIZE(16), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .gpio_raw(raw), .status_clr(clr), .irq_mask(mask),
    .gpio_stable(st0), .gpio_rise(ri0), .gpio_fall(fa0), .edge_status(es0), .irq(irq0)
  );
  sm_gpio_debounce #(.GPIO_SIZE(16), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .gpio_raw(raw), .status_clr(clr), .irq_mask(mask),
    .gpio_stable(st1), .gpio_rise(ri1), .gpio_fall(fa1), .edge_status(es1), .irq(irq1)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic cmp(string n, int c, string f, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s cyc %0d: got %h expected %h", n, f, c, act, exp);
    end
  endtask
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      cmp(e.name, e.cyc, "cycle", 16'(cyc), 16'(e.cyc));
      cmp(e.name, e.cyc, "stable", e.u ? st1 : st0, e.st);
      cmp(e.name, e.cyc, "rise", e.u ? ri1 : ri0, e.ri);
      cmp(e.name, e.cyc, "fall", e.u ? fa1 : fa0, e.fa);
      cmp(e.name, e.cyc, "status", e.u ? es1 : es0, e.es);
      cmp(e.name, e.cyc, "irq", {15'b0, e.u ? irq1 : irq0}, {15'b0, e.irq});
    end
  end
  task automatic push(int u, string nm, logic [15:0] s, logic [15:0] r, logic [15:0] f, logic [15:0] e, logic i);
    exp_t x;
    x.cyc = cyc + 1;
    x.u = u;
    x.name = nm;
    x.st = s;
    x.ri = r;
    x.fa = f;
    x.es = e;
    x.irq = i;
    q.push_back(x);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(int n, string nm, logic [15:0] s, logic [15:0] r, logic [15:0] f, logic [15:0] e, logic i);
    repeat (n) begin
      push(0, nm, s, r, f, e, i);
      tick();
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1;
    raw = 16'h0000;
    clr = 16'h0000;
    mask = 16'hffff;
    for (int k = 0; k < 4; k++) begin
      push(0, "reset", 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
      push(1, "reset_d1", 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
      tick();
    end
    rst = 1'b0;
    raw = 16'h000a;
    for (int k = 0; k < 9; k++) begin
      push(0, "s1_d4", k < 5 ? 16'h0 : 16'h000a, k == 5 ? 16'h000a : 16'h0, 16'h0, k < 5 ? 16'h0 : 16'h000a, k >= 5);
      push(1, "s1_d1", k < 2 ? 16'h0 : 16'h000a, k == 2 ? 16'h000a : 16'h0, 16'h0, k < 2 ? 16'h0 : 16'h000a, k >= 2);
      tick();
    end
    raw = 16'h000b;
    run(3, "s2_glitch", 16'h000a, 16'h0, 16'h0, 16'h000a, 1'b1);
    raw = 16'h000a;
    run(8, "s2_reject", 16'h000a, 16'h0, 16'h0, 16'h000a, 1'b1);
    raw = 16'h0002;
    run(5, "s3_wait", 16'h000a, 16'h0, 16'h0, 16'h000a, 1'b1);
    run(1, "s3_fall", 16'h0002, 16'h0, 16'h0008, 16'h000a, 1'b1);
    clr = 16'h0008;
    run(1, "s3_clr", 16'h0002, 16'h0, 16'h0, 16'h0002, 1'b1);
    clr = 16'h0002;
    run(1, "s3_clr2", 16'h0002, 16'h0, 16'h0, 16'h0000, 1'b0);
    clr = 16'h0000;
    run(2, "s3_idle", 16'h0002, 16'h0, 16'h0, 16'h0000, 1'b0);
    raw = 16'h0003;
    run(4, "s4_wait", 16'h0002, 16'h0, 16'h0, 16'h0, 1'b0);
    raw = 16'h0002;
    run(1, "s4_wait", 16'h0002, 16'h0, 16'h0, 16'h0, 1'b0);
    clr = 16'h0001;
    run(1, "s4_setwins", 16'h0003, 16'h0001, 16'h0, 16'h0001, 1'b1);
    clr = 16'h0000;
    run(3, "s4_hold", 16'h0003, 16'h0, 16'h0, 16'h0001, 1'b1);
    run(1, "s4_fall", 16'h0002, 16'h0, 16'h0001, 16'h0001, 1'b1);
    run(1, "s4_post", 16'h0002, 16'h0, 16'h0, 16'h0001, 1'b1);
    clr = 16'h0001;
    mask = 16'h0000;
    run(1, "s5_clr", 16'h0002, 16'h0, 16'h0, 16'h0, 1'b0);
    clr = 16'h0000;
    raw = 16'h0022;
    run(5, "s5_wait", 16'h0002, 16'h0, 16'h0, 16'h0, 1'b0);
    run(1, "s5_rise", 16'h0022, 16'h0020, 16'h0, 16'h0020, 1'b0);
    mask = 16'h0020;
    run(1, "s5_unmask", 16'h0022, 16'h0, 16'h0, 16'h0020, 1'b1);
    mask = 16'hffff;
    raw = 16'h0032;
    run(4, "s6_count", 16'h0022, 16'h0, 16'h0, 16'h0020, 1'b1);
    rst = 1'b1;
    run(1, "s6_rst", 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    rst = 1'b0;
    run(5, "s6_relwait", 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    run(1, "s6_rise", 16'h0032, 16'h0032, 16'h0, 16'h0032, 1'b1);
    run(1, "s6_hold", 16'h0032, 16'h0, 16'h0, 16'h0032, 1'b1);
    raw = 16'h0033;
    run(4, "s6_count2", 16'h0032, 16'h0, 16'h0, 16'h0032, 1'b1);
    rst = 1'b1;
    raw = 16'h0000;
    run(1, "s6_rst2", 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    rst = 1'b0;
    run(8, "s6_quiet", 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    tick();
    tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
